// File: rtl/flap_pkg.sv
// flap_pkg: shared types and constants for the flappy-bird game-flow controller.
// Holds the 2-bit game state encoding, BCD limits and the blink period, plus
// a saturating two-digit BCD increment used by the score path.
package flap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [7:0] BCD_MAX      = 8'h99;
  localparam int         BLINK_PERIOD = 8;

  // Two-digit BCD +1 that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v >= BCD_MAX) begin
      r = BCD_MAX;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/flap_bcd_counter.sv
// flap_bcd_counter: two-digit BCD counter with synchronous clear, increment
// enable and saturation at 99. Clear has priority over increment.
module flap_bcd_counter
  import flap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;

  // Count register: clear wins, otherwise saturating BCD increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 8'h00;
    end else if (clr_i) begin
      count_q <= 8'h00;
    end else if (inc_i) begin
      count_q <= bcd_inc(count_q);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/flap_sequencer.sv
// flap_sequencer: game-flow controller for the VGA flappy-bird design.
// Derives a per-frame tick from the falling edge of v_sync, samples the
// synchronised button once per frame (frame-rate sampling is the debounce),
// and runs the IDLE/PLAY/DEAD/OVER state machine that gates physics and
// owns score, high score and pipe speed.
// Optional feature: define FLAP_HIGH_SCORE_EN to build the high-score
// register and compare; otherwise high_score is tied to zero.
module flap_sequencer
  import flap_pkg::*;
#(
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_STEP   = 8,
  parameter int MAX_SPEED    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       button,
  input  logic       collision,
  input  logic       pipe_passed,
  output logic       frame_tick,
  output logic       run,
  output logic       flap,
  output logic       game_reset,
  output logic [2:0] speed,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] state,
  output logic       blink
);

  // Input conditioning registers.
  logic vs_q;           // v_sync as registered from the pins
  logic vs_qq;          // one frame-edge-detect delay
  logic btn_meta_q;
  logic btn_sync_q;
  logic frame_tick_q;

  // FSM and datapath registers.
  state_e     state_q;
  logic       run_q;
  logic       flap_q;
  logic       game_reset_q;
  logic       blink_q;
  logic       sticky_q;
  logic       press_hist_q;
  logic [2:0] speed_q;
  logic [7:0] pass_q;
  logic [7:0] step_q;
  logic [7:0] dead_cnt_q;

  // Combinational decode.
  logic       tick;       // internal tick; frame_tick is this delayed one cycle
  logic       press;
  logic       coll_now;
  logic       pass_ev;
  logic       start;
  logic [7:0] dead_inc;
  logic       blink_edge;
  logic [7:0] score_w;

  // Falling v_sync seen between the two pin registers. Decisions are taken on
  // this edge so flap/game_reset/state land in the same cycle as frame_tick.
  assign tick       = vs_qq & ~vs_q;
  assign press      = btn_sync_q & ~press_hist_q;
  assign coll_now   = sticky_q | collision;
  assign pass_ev    = (state_q == ST_PLAY) & pipe_passed;
  assign start      = tick & (state_q == ST_IDLE) & press;
  assign dead_inc   = dead_cnt_q + 8'd1;
  assign blink_edge = ((dead_inc % 8'(BLINK_PERIOD)) == 8'd0);

  // v_sync edge pipeline, button synchroniser and frame_tick output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q         <= 1'b1;
      vs_qq        <= 1'b1;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_q         <= v_sync;
      vs_qq        <= vs_q;
      btn_meta_q   <= button;
      btn_sync_q   <= btn_meta_q;
      frame_tick_q <= tick;
    end
  end

  // Score is cleared on game start and counts passes only while playing.
  flap_bcd_counter u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start),
    .inc_i   (pass_ev),
    .count_o (score_w)
  );

  // Game state machine with registered run/flap/game_reset/blink/speed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      flap_q       <= 1'b0;
      game_reset_q <= 1'b0;
      blink_q      <= 1'b0;
      sticky_q     <= 1'b0;
      press_hist_q <= 1'b0;
      speed_q      <= 3'd1;
      pass_q       <= 8'd0;
      step_q       <= 8'd0;
      dead_cnt_q   <= 8'd0;
    end else begin
      flap_q       <= 1'b0;
      game_reset_q <= 1'b0;
      // run follows the state one cycle late
      run_q        <= (state_q == ST_PLAY);

      // Collision is sticky within a frame; a datapath reinit also clears it.
      if (tick || game_reset_q) begin
        sticky_q <= 1'b0;
      end else if (collision) begin
        sticky_q <= 1'b1;
      end

      if (tick) begin
        press_hist_q <= btn_sync_q;
      end

      unique case (state_q)
        ST_IDLE: begin
          blink_q <= 1'b0;
          if (start) begin
            game_reset_q <= 1'b1;
            flap_q       <= 1'b1;
            speed_q      <= 3'd1;
            pass_q       <= 8'd0;
            step_q       <= 8'd0;
            state_q      <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          // Pass counter saturates at 255; speed steps every LEVEL_STEP passes.
          if (pass_ev && (pass_q != 8'hFF)) begin
            pass_q <= pass_q + 8'd1;
            if (step_q == 8'(LEVEL_STEP - 1)) begin
              step_q <= 8'd0;
              if (speed_q < 3'(MAX_SPEED)) begin
                speed_q <= speed_q + 3'd1;
              end
            end else begin
              step_q <= step_q + 8'd1;
            end
          end
          if (tick) begin
            if (coll_now) begin
              // death wins over a simultaneous press: no flap
              dead_cnt_q <= 8'd0;
              blink_q    <= 1'b0;
              state_q    <= ST_DEAD;
            end else if (press) begin
              flap_q <= 1'b1;
            end
          end
        end

        ST_DEAD: begin
          if (tick) begin
            if (dead_cnt_q == 8'(DEATH_FRAMES - 1)) begin
              blink_q <= 1'b1;
              state_q <= ST_OVER;
            end else begin
              dead_cnt_q <= dead_inc;
              if (blink_edge) begin
                blink_q <= ~blink_q;
              end
            end
          end
        end

        ST_OVER: begin
          blink_q <= 1'b1;
          if (tick && press) begin
            blink_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FLAP_HIGH_SCORE_EN
  logic [7:0] high_score_q;
  logic [7:0] score_post;

  // A pass on the dying tick still counts toward the compare.
  assign score_post = pass_ev ? bcd_inc(score_w) : score_w;

  // High score captured on the PLAY->DEAD tick when beaten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_score_q <= 8'h00;
    end else if (tick && (state_q == ST_PLAY) && coll_now &&
                 (score_post > high_score_q)) begin
      high_score_q <= score_post;
    end
  end

  assign high_score = high_score_q;
`else
  assign high_score = 8'h00;
`endif

  assign frame_tick = frame_tick_q;
  assign run        = run_q;
  assign flap       = flap_q;
  assign game_reset = game_reset_q;
  assign speed      = speed_q;
  assign score      = score_w;
  assign state      = state_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_flap_sequencer.sv
// tb_flap_sequencer: frame-level bench for flap_sequencer. A table of frame
// records drives the main game flow; hand sequences cover DEAD/OVER timing,
// score latency and mid-game reset. Per-tick outputs go through an expected
// queue checked by a monitor whenever frame_tick is seen.
module tb_flap_sequencer;
  import flap_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v_sync;
  logic       button;
  logic       collision;
  logic       pipe_passed;
  logic       frame_tick;
  logic       run;
  logic       flap;
  logic       game_reset;
  logic [2:0] speed;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] state;
  logic       blink;

`ifdef FLAP_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  flap_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .v_sync      (v_sync),
    .button      (button),
    .collision   (collision),
    .pipe_passed (pipe_passed),
    .frame_tick  (frame_tick),
    .run         (run),
    .flap        (flap),
    .game_reset  (game_reset),
    .speed       (speed),
    .score       (score),
    .high_score  (high_score),
    .state       (state),
    .blink       (blink)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];   // {state, flap, game_reset} expected at each tick
  logic [3:0] mon_e;
  logic       run_at_tick;

  typedef struct {
    logic       btn;
    int         npass;
    logic       coll;
    logic [1:0] st;
    logic       fl;
    logic       gr;
    logic [7:0] sc;
    logic [2:0] sp;
    logic [7:0] hs;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard: pop one expectation per observed frame_tick
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_tick) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tick_outputs", {28'd0, state, flap, game_reset}, {28'd0, mon_e});
        end
      end else if (flap || game_reset) begin
        chk("pulse_off_tick", {30'd0, flap, game_reset}, 32'd0);
      end
    end
  end

  // driver: one frame with button level, pipe passes and optional collision
  task automatic run_frame(input logic btn, input int npass, input logic coll,
                           input logic [3:0] exp_tick);
    button = btn;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < npass; i++) begin
      pipe_passed = 1'b1;
      @(posedge clk); #1;
      pipe_passed = 1'b0;
      @(posedge clk); #1;
    end
    if (coll) begin
      collision = 1'b1;
      @(posedge clk); #1;
      collision = 1'b0;
    end
    @(posedge clk); #1;
    exp_q.push_back(exp_tick);
    v_sync = 1'b0;
    @(posedge clk); #1;
    chk("tick_not_early", {31'd0, frame_tick}, 32'd0);
    @(posedge clk); #1;
    run_at_tick = run;
    v_sync = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    run_frame(v.btn, v.npass, v.coll, {v.st, v.fl, v.gr});
    chk("score", {24'd0, score}, {24'd0, v.sc});
    chk("speed", {29'd0, speed}, {29'd0, v.sp});
    chk("high_score", {24'd0, high_score}, {24'd0, v.hs});
    chk("run", {31'd0, run}, {31'd0, (v.st == 2'd1)});
    if (v.gr) chk("run_lags_tick", {31'd0, run_at_tick}, 32'd0);
  endtask

  // 60 ticks in DEAD with button chatter and ignored passes, then OVER, press -> IDLE
  task automatic dead_phase(input logic [7:0] exp_sc);
    for (int k = 1; k <= 60; k++) begin
      run_frame((k < 60) ? logic'(k % 2) : 1'b0, (k == 5) ? 2 : 0, 1'b0,
                {(k == 60) ? 2'd3 : 2'd2, 1'b0, 1'b0});
      chk("dead_blink", {31'd0, blink}, (k == 60) ? 32'd1 : 32'((k / 8) % 2));
      chk("dead_score", {24'd0, score}, {24'd0, exp_sc});
      if (k == 1) chk("dead_run", {31'd0, run}, 32'd0);
    end
    run_frame(1'b1, 0, 1'b0, {2'd0, 1'b0, 1'b0});
    chk("over_exit_score", {24'd0, score}, {24'd0, exp_sc});
    chk("idle_run", {31'd0, run}, 32'd0);
    run_frame(1'b0, 0, 1'b0, {2'd0, 1'b0, 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; v_sync = 1'b1; button = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_pulses", {29'd0, frame_tick, flap, game_reset}, 32'd0);
    chk("rst_speed", {29'd0, speed}, 32'd1);
    chk("rst_score", {24'd0, score}, 32'd0);
    chk("rst_high", {24'd0, high_score}, 32'd0);
    chk("rst_blink", {31'd0, blink}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //           btn   np  coll  st    fl    gr    sc     sp    hs
    vecs[0]  = '{1'b0, 0,  1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1, 8'h00};
    vecs[1]  = '{1'b1, 0,  1'b0, 2'd1, 1'b1, 1'b1, 8'h00, 3'd1, 8'h00};
    vecs[2]  = '{1'b1, 0,  1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 3'd1, 8'h00};
    vecs[3]  = '{1'b1, 0,  1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 3'd1, 8'h00};
    vecs[4]  = '{1'b0, 3,  1'b0, 2'd1, 1'b0, 1'b0, 8'h03, 3'd1, 8'h00};
    vecs[5]  = '{1'b1, 0,  1'b0, 2'd1, 1'b1, 1'b0, 8'h03, 3'd1, 8'h00};
    vecs[6]  = '{1'b0, 2,  1'b0, 2'd1, 1'b0, 1'b0, 8'h05, 3'd1, 8'h00};
    vecs[7]  = '{1'b0, 1,  1'b1, 2'd2, 1'b0, 1'b0, 8'h06, 3'd1, HS_EN ? 8'h06 : 8'h00};
    vecs[8]  = '{1'b1, 0,  1'b0, 2'd1, 1'b1, 1'b1, 8'h00, 3'd1, HS_EN ? 8'h06 : 8'h00};
    vecs[9]  = '{1'b0, 9,  1'b0, 2'd1, 1'b0, 1'b0, 8'h09, 3'd2, HS_EN ? 8'h06 : 8'h00};
    vecs[10] = '{1'b0, 91, 1'b0, 2'd1, 1'b0, 1'b0, 8'h99, 3'd4, HS_EN ? 8'h06 : 8'h00};
    vecs[11] = '{1'b1, 0,  1'b1, 2'd2, 1'b0, 1'b0, 8'h99, 3'd4, HS_EN ? 8'h99 : 8'h00};

    for (int i = 0; i < 8; i++) apply_vec(i);
    dead_phase(8'h06);
    for (int i = 8; i < 12; i++) apply_vec(i);
    dead_phase(8'h99);

    // score latency: updates the cycle after a pipe_passed pulse
    run_frame(1'b1, 0, 1'b0, {2'd1, 1'b1, 1'b1});
    chk("restart_score", {24'd0, score}, 32'd0);
    chk("restart_speed", {29'd0, speed}, 32'd1);
    pipe_passed = 1'b1;
    @(negedge clk);
    chk("score_before_edge", {24'd0, score}, 32'd0);
    @(posedge clk); #1;
    pipe_passed = 1'b0;
    chk("score_after_pulse", {24'd0, score}, 32'h01);
    run_frame(1'b0, 11, 1'b0, {2'd1, 1'b0, 1'b0});
    chk("pre_rst_score", {24'd0, score}, 32'h12);
    chk("pre_rst_speed", {29'd0, speed}, 32'd2);
    chk("pre_rst_high", {24'd0, high_score}, HS_EN ? 32'h99 : 32'h00);

    // one-cycle reset mid-PLAY
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_score", {24'd0, score}, 32'd0);
    chk("midrst_high", {24'd0, high_score}, 32'd0);
    chk("midrst_run", {31'd0, run}, 32'd0);
    chk("midrst_speed", {29'd0, speed}, 32'd1);
    run_frame(1'b0, 0, 1'b0, {2'd0, 1'b0, 1'b0});

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
